// File: rtl/seq_alu.sv
// Registered execute-stage ALU with valid/ready handshakes on input and output.
// MUL is shift-add and DIVU/REMU are restoring division, each retiring one bit per cycle.
module seq_alu #(
    parameter int unsigned WIDTH = 16,
    localparam int unsigned SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_code,
    input  logic [WIDTH-1:0] reg_data1,
    input  logic [WIDTH-1:0] reg_data2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] accum,
    output logic [WIDTH-1:0] accum_hi,
    output logic             pc_branch,
    output logic             carry,
    output logic             zero,
    output logic             div_by_zero
);
    localparam logic [3:0] OpAnd  = 4'b0001;
    localparam logic [3:0] OpOr   = 4'b0010;
    localparam logic [3:0] OpXor  = 4'b0011;
    localparam logic [3:0] OpSub  = 4'b0100;
    localparam logic [3:0] OpShl  = 4'b0101;
    localparam logic [3:0] OpShr  = 4'b0110;
    localparam logic [3:0] OpAdd  = 4'b1000;
    localparam logic [3:0] OpMul  = 4'b1001;
    localparam logic [3:0] OpDivu = 4'b1010;
    localparam logic [3:0] OpRemu = 4'b1011;
    localparam logic [3:0] OpBeq  = 4'b1100;
    localparam logic [3:0] OpBlt  = 4'b1101;
    localparam logic [3:0] OpBgt  = 4'b1110;

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    state_e           state;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] work_hi;
    logic [WIDTH-1:0] work_lo;
    logic [SHW-1:0]   cnt;

    logic [WIDTH:0]   add_sum, sub_diff;
    logic [WIDTH-1:0] sc_acc, dz_acc;
    logic             sc_carry, sc_branch, sc_known, is_multi, is_dz;

    always_comb begin
        add_sum   = {1'b0, reg_data1} + {1'b0, reg_data2};
        sub_diff  = {1'b0, reg_data1} - {1'b0, reg_data2};
        sc_acc    = '0;
        sc_carry  = 1'b0;
        sc_branch = 1'b0;
        sc_known  = 1'b1;
        case (alu_code)
            OpAnd: sc_acc = reg_data1 & reg_data2;
            OpOr:  sc_acc = reg_data1 | reg_data2;
            OpXor: sc_acc = reg_data1 ^ reg_data2;
            OpSub: begin
                sc_acc   = sub_diff[WIDTH-1:0];
                sc_carry = sub_diff[WIDTH];
            end
            OpShl: sc_acc = reg_data1 << reg_data2[SHW-1:0];
            OpShr: sc_acc = reg_data1 >> reg_data2[SHW-1:0];
            OpAdd: begin
                sc_acc   = add_sum[WIDTH-1:0];
                sc_carry = add_sum[WIDTH];
            end
            OpBeq: sc_branch = (reg_data1 == reg_data2);
            OpBlt: sc_branch = (reg_data1 < reg_data2);
            OpBgt: sc_branch = (reg_data1 > reg_data2);
            default: sc_known = 1'b0;
        endcase
        is_multi = alu_code inside {OpMul, OpDivu, OpRemu};
        is_dz    = (alu_code inside {OpDivu, OpRemu}) && (reg_data2 == '0);
        dz_acc   = (alu_code == OpDivu) ? '1 : reg_data1;
    end

    // One iteration: MUL keeps {hi,lo} as the product shifter, division keeps {rem,quot}.
    logic [WIDTH:0]   mul_sum, div_shift, div_trial;
    logic             div_ge;
    logic [WIDTH-1:0] step_hi, step_lo, fin_acc, fin_hi;

    always_comb begin
        mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opb_q} : '0);
        div_shift = {work_hi, work_lo[WIDTH-1]};
        div_trial = div_shift - {1'b0, opb_q};
        div_ge    = (div_shift >= {1'b0, opb_q});
        if (op_q == OpMul) begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], work_lo[WIDTH-1:1]};
        end else begin
            step_hi = div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
            step_lo = {work_lo[WIDTH-2:0], div_ge};
        end
        fin_hi  = '0;
        fin_acc = step_lo;
        if (op_q == OpMul) begin
            fin_hi = step_hi;
        end else if (op_q == OpRemu) begin
            fin_acc = step_hi;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StIdle;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            accum       <= '0;
            accum_hi    <= '0;
            pc_branch   <= 1'b0;
            carry       <= 1'b0;
            zero        <= 1'b0;
            div_by_zero <= 1'b0;
            op_q        <= '0;
            opb_q       <= '0;
            work_hi     <= '0;
            work_lo     <= '0;
            cnt         <= '0;
        end else begin
            case (state)
                StIdle: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        op_q     <= alu_code;
                        opb_q    <= reg_data2;
                        if (is_multi && !is_dz) begin
                            work_hi <= '0;
                            work_lo <= reg_data1;
                            cnt     <= '0;
                            state   <= StExec;
                        end else begin
                            state     <= StDone;
                            out_valid <= 1'b1;
                            accum_hi  <= '0;
                            if (is_dz) begin
                                accum       <= dz_acc;
                                div_by_zero <= 1'b1;
                                zero        <= (dz_acc == '0);
                                carry       <= 1'b0;
                                pc_branch   <= 1'b0;
                            end else begin
                                accum       <= sc_acc;
                                carry       <= sc_carry;
                                pc_branch   <= sc_branch;
                                zero        <= sc_known && (sc_acc == '0);
                                div_by_zero <= 1'b0;
                            end
                        end
                    end
                end
                StExec: begin
                    work_hi <= step_hi;
                    work_lo <= step_lo;
                    cnt     <= cnt + 1'b1;
                    if (cnt == SHW'(WIDTH - 1)) begin
                        state       <= StDone;
                        out_valid   <= 1'b1;
                        accum       <= fin_acc;
                        accum_hi    <= fin_hi;
                        zero        <= (fin_acc == '0) && (fin_hi == '0);
                        carry       <= 1'b0;
                        pc_branch   <= 1'b0;
                        div_by_zero <= 1'b0;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid   <= 1'b0;
                        pc_branch   <= 1'b0;
                        carry       <= 1'b0;
                        zero        <= 1'b0;
                        div_by_zero <= 1'b0;
                        in_ready    <= 1'b1;
                        state       <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: directed vector table, handshake/reset corner sequences and
// random operations scored against an arithmetic reference model.
module tb_seq_alu;
    localparam int unsigned WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [3:0]       alu_code = '0;
    logic [WIDTH-1:0] reg_data1 = '0;
    logic [WIDTH-1:0] reg_data2 = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] accum, accum_hi;
    logic             pc_branch, carry, zero, div_by_zero;

    int n_checks = 0;
    int n_fail = 0;
    logic [3:0] cur_code = '0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_code(alu_code), .reg_data1(reg_data1), .reg_data2(reg_data2),
        .out_valid(out_valid), .out_ready(out_ready), .accum(accum), .accum_hi(accum_hi),
        .pc_branch(pc_branch), .carry(carry), .zero(zero), .div_by_zero(div_by_zero)
    );

    typedef struct {
        logic [3:0]  code;
        logic [15:0] a, b, acc, hi;
        logic        br, cy, z, dbz;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (op %b): got 0x%0h, expected 0x%0h", name, cur_code, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] acc, input logic [15:0] hi, input logic br,
                                input logic cy, input logic z, input logic dbz, input int lat);
        vec_t v;
        v.code = c; v.a = a; v.b = b; v.acc = acc; v.hi = hi;
        v.br = br; v.cy = cy; v.z = z; v.dbz = dbz; v.lat = lat;
        return v;
    endfunction

    function automatic bit known_code(input logic [3:0] c);
        return !(c inside {4'b0000, 4'b0111, 4'b1111});
    endfunction

    // Reference: results straight from the arithmetic definition of each opcode.
    function automatic vec_t model(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b);
        vec_t r;
        logic [31:0] p;
        logic [16:0] s;
        r = mk(c, a, b, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        case (c)
            4'b0001: r.acc = a & b;
            4'b0010: r.acc = a | b;
            4'b0011: r.acc = a ^ b;
            4'b0100: begin r.acc = a - b; r.cy = (a < b); end
            4'b0101: r.acc = a << b[3:0];
            4'b0110: r.acc = a >> b[3:0];
            4'b1000: begin s = {1'b0, a} + {1'b0, b}; r.acc = s[15:0]; r.cy = s[16]; end
            4'b1001: begin
                p = {16'h0, a} * {16'h0, b};
                r.acc = p[15:0]; r.hi = p[31:16]; r.lat = 17;
            end
            4'b1010: if (b == 0) begin r.acc = 16'hFFFF; r.dbz = 1'b1; end
                     else begin r.acc = a / b; r.lat = 17; end
            4'b1011: if (b == 0) begin r.acc = a; r.dbz = 1'b1; end
                     else begin r.acc = a % b; r.lat = 17; end
            4'b1100: r.br = (a == b);
            4'b1101: r.br = (a < b);
            4'b1110: r.br = (a > b);
            default: ;
        endcase
        r.z = known_code(c) && (r.acc == 0) && (r.hi == 0);
        return r;
    endfunction

    // Starts and ends on a falling edge.
    task automatic run_op(input vec_t v, input int hold, input bit early);
        int lat;
        int guard = 0;
        cur_code = v.code;
        out_ready = early;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_idle", in_ready, 1);
        alu_code = v.code; reg_data1 = v.a; reg_data2 = v.b; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 40) begin
            check("in_ready_exec", in_ready, 0);
            alu_code = 4'($urandom); reg_data1 = 16'($urandom); reg_data2 = 16'($urandom);
            @(negedge clk);
            lat++;
        end
        check("latency", lat, v.lat);
        check("accum", accum, v.acc);
        check("accum_hi", accum_hi, v.hi);
        check("pc_branch", pc_branch, v.br);
        check("carry", carry, v.cy);
        if (known_code(v.code)) check("zero", zero, v.z);
        check("div_by_zero", div_by_zero, v.dbz);
        check("in_ready_done", in_ready, 0);
        if (!early) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check("hold_valid", out_valid, 1);
                check("hold_accum", accum, v.acc);
                check("hold_in_ready", in_ready, 0);
            end
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check("hs_valid", out_valid, 0);
        check("hs_in_ready", in_ready, 1);
        check("hs_flags", {pc_branch, carry, zero, div_by_zero}, 0);
        out_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[$];
        vec_t v;
        logic [3:0] c;
        logic [15:0] a, b;
        logic stuck;

        tbl.push_back(mk(4'b1000, 16'h0001, 16'h003F, 16'h0040, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(4'b1000, 16'hFFFF, 16'h0001, 16'h0000, 0, 0, 1, 1, 0, 1));
        tbl.push_back(mk(4'b0100, 16'h003F, 16'h0001, 16'h003E, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(4'b0100, 16'h0001, 16'h0002, 16'hFFFF, 0, 0, 1, 0, 0, 1));
        tbl.push_back(mk(4'b1100, 16'h0001, 16'h0001, 16'h0000, 0, 1, 0, 1, 0, 1));
        tbl.push_back(mk(4'b1100, 16'h0001, 16'h0002, 16'h0000, 0, 0, 0, 1, 0, 1));
        tbl.push_back(mk(4'b1101, 16'h0001, 16'h0003, 16'h0000, 0, 1, 0, 1, 0, 1));
        tbl.push_back(mk(4'b1101, 16'h0003, 16'h0001, 16'h0000, 0, 0, 0, 1, 0, 1));
        tbl.push_back(mk(4'b1110, 16'h0003, 16'h0001, 16'h0000, 0, 1, 0, 1, 0, 1));
        tbl.push_back(mk(4'b1110, 16'h0001, 16'h0003, 16'h0000, 0, 0, 0, 1, 0, 1));
        tbl.push_back(mk(4'b1001, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 0, 0, 0, 0, 17));
        tbl.push_back(mk(4'b1001, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 0, 0, 1, 0, 17));
        tbl.push_back(mk(4'b1010, 16'd100, 16'd7, 16'd14, 0, 0, 0, 0, 0, 17));
        tbl.push_back(mk(4'b1011, 16'd100, 16'd7, 16'd2, 0, 0, 0, 0, 0, 17));
        tbl.push_back(mk(4'b1010, 16'd3, 16'd7, 16'd0, 0, 0, 0, 1, 0, 17));
        tbl.push_back(mk(4'b1011, 16'd6, 16'd3, 16'd0, 0, 0, 0, 1, 0, 17));
        tbl.push_back(mk(4'b1010, 16'd5, 16'd0, 16'hFFFF, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(4'b1011, 16'd5, 16'd0, 16'd5, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(4'b0001, 16'hF0F0, 16'hFF00, 16'hF000, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(4'b0010, 16'hF0F0, 16'hFF00, 16'hFFF0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(4'b0011, 16'hF0F0, 16'hFF00, 16'h0FF0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(4'b0101, 16'h0001, 16'h0013, 16'h0008, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(4'b0110, 16'h8000, 16'h000F, 16'h0001, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(4'b0000, 16'h0005, 16'h0003, 16'h0000, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(4'b0111, 16'hFFFF, 16'h0001, 16'h0000, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(4'b1111, 16'h0003, 16'h0003, 16'h0000, 0, 0, 0, 0, 0, 1));

        // Reset state.
        #1 rst_n = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_outputs", {accum, accum_hi, pc_branch, carry, zero, div_by_zero}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_in_ready", in_ready, 1);
        @(negedge clk);

        foreach (tbl[i]) run_op(tbl[i], i % 3, (i % 4) == 3);

        // Backpressure: result held for five cycles.
        run_op(tbl[10], 5, 1'b0);

        // Asynchronous reset in the middle of a MUL.
        cur_code = 4'b1001;
        alu_code = 4'b1001; reg_data1 = 16'hFFFF; reg_data2 = 16'hFFFF; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_outputs", {accum, accum_hi, pc_branch, carry, zero, div_by_zero}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("mid_rel_in_ready_pre", in_ready, 0);
        @(posedge clk);
        #1;
        check("mid_rel_in_ready", in_ready, 1);
        stuck = 1'b0;
        repeat (20) begin
            @(negedge clk);
            stuck = stuck | out_valid;
        end
        check("no_spurious_valid", stuck, 0);
        run_op(tbl[0], 0, 1'b0);

        // Random operations against the reference model.
        for (int n = 0; n < 60; n++) begin
            c = 4'($urandom_range(0, 15));
            a = 16'($urandom);
            case ($urandom % 4)
                0: b = 16'h0;
                1: b = 16'($urandom_range(1, 15));
                default: b = 16'($urandom);
            endcase
            v = model(c, a, b);
            run_op(v, $urandom_range(0, 3), 1'($urandom % 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised, registered ALU for the CPU execute stage.
- Replaces the purely combinational ALU.
- Adds valid/ready handshakes on input and output.
- Adds iterative multi-cycle MUL (double-width result), DIVU and REMU.
- Adds status flags.
- Keeps the existing opcode encodings for ADD, SUB and the compare-branch ops.

Parameters:
WIDTH, 16, operand/result width in bits (>=4, power of two)
SHW, $clog2(WIDTH), shift-amount field width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operation request
in_ready  output  1  block can accept an operation
alu_code  input  4  opcode
reg_data1  input  WIDTH  operand A
reg_data2  input  WIDTH  operand B
out_valid  output  1  result valid
out_ready  input  1  consumer takes result
accum  output  WIDTH  result (low half for MUL)
accum_hi  output  WIDTH  MUL high half; 0 for all other ops
pc_branch  output  1  branch taken (compare ops only)
carry  output  1  ADD carry-out / SUB borrow; 0 otherwise
zero  output  1  accum==0 (and accum_hi==0 for MUL)
div_by_zero  output  1  DIVU/REMU with B==0

Behaviour:
- Opcodes:
  - 0001 AND; 0010 OR; 0011 XOR.
  - 0100 SUB (A-B mod 2^WIDTH; borrow=A<B).
  - 0101 SHL A by B[SHW-1:0]; 0110 SHR (logical), same shift amount.
  - 1000 ADD.
  - 1001 MUL (unsigned); 1010 DIVU (quotient); 1011 REMU (remainder).
  - 1100 BEQ (A==B); 1101 BLT (A<B unsigned); 1110 BGT (A>B unsigned).
  - Compare ops: accum=0, pc_branch=comparison result.
  - Any other code: all result outputs 0, latency 1.
- FSM states: IDLE, EXEC, DONE.
- in_ready=1 only in IDLE. Accept when in_valid&&in_ready. Operands and opcode are captured at accept; later input changes are ignored.
- Single-cycle ops: IDLE->DONE. out_valid rises on the clock after accept (latency 1).
- MUL/DIVU/REMU: IDLE->EXEC.
  - MUL is shift-add, one bit per cycle; DIVU/REMU are restoring division, one bit per cycle.
  - Iteration counter runs WIDTH cycles, then EXEC->DONE.
  - out_valid rises WIDTH+1 cycles after accept.
- DIVU/REMU with B==0 bypass EXEC and go directly to DONE (latency 1):
  - quotient = all ones, remainder = A, div_by_zero=1.
- DONE: out_valid=1; all result outputs are held stable until out_valid&&out_ready.
- Handshake completes on that same edge: out_valid drops, DONE->IDLE.
- No pipelining: the next accept occurs at the earliest the cycle after the output handshake. Max throughput is one op per 2 cycles.
- Flags are registered with accum and valid only while out_valid=1. They are cleared to 0 on output handshake.
- out_ready may be high before out_valid. It has no effect outside DONE.
- Reset (asynchronous, any state, including mid-EXEC):
  - state=IDLE; in-flight op discarded.
  - in_ready=0 while rst_n=0, and 1 from the first clock after release.
  - out_valid, accum, accum_hi, pc_branch, carry, zero, div_by_zero all 0; counter 0.
- Arithmetic is unsigned, modulo 2^WIDTH except MUL (full 2*WIDTH).
- Shift amount >= WIDTH cannot occur; only SHW bits are used.

Test Plan:
- ADD A=0x0001 B=0x003F, out_ready=1 -> out_valid at cycle+1: accum=0x0040, carry=0, zero=0. ADD 0xFFFF+0x0001 -> accum=0x0000, carry=1, zero=1.
- SUB 0x003F-0x0001 -> 0x003E, carry=0. BEQ 1,1 -> pc_branch=1, accum=0. BLT 1,3 -> pc_branch=1. BLT 3,1 -> 0. BGT 3,1 -> 1. BGT 1,3 -> 0.
- MUL 0xFFFF*0xFFFF -> out_valid exactly 17 cycles after accept: accum=0x0001, accum_hi=0xFFFE. in_ready=0 throughout EXEC/DONE.
- DIVU 100/7 -> 14 after 17 cycles. REMU 100/7 -> 2. DIVU 5/0 -> cycle+1: accum=0xFFFF, div_by_zero=1. REMU 5/0 -> accum=5.
- Backpressure: out_ready=0 for 5 cycles after result -> out_valid and accum held constant, in_ready=0. Raise out_ready -> handshake, then in_ready=1 next cycle. Input operands changed mid-EXEC do not alter the result.
- Assert rst_n=0 at iteration 8 of a MUL -> all outputs 0 immediately (asynchronous). After release: in_ready=1, no spurious out_valid. A new ADD completes normally.
